// File: rtl/com_pkg.sv
// Shared types and helpers for the COM stream transmitter.
package com_pkg;

   // Serialiser FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } com_state_e;

   // Width of the optional dropped-word counter
   localparam int DROP_CNT_W = 8;

   // Number of OUT_W beats in one DATA_W word
   function automatic int beats(input int data_w, input int out_w);
      return data_w / out_w;
   endfunction

endpackage

// File: rtl/com_fifo.sv
// Synchronous FIFO, first-word fall-through on dout_o.
// A pop on a full FIFO frees the slot first, so a same-cycle push is accepted.
module com_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Occupancy update from accepted push/pop
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage array; contents are don't-care once pointers are flushed
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/com_stream_tx.sv
// COM stream transmitter: captures COM-flagged memory reads into a FIFO and
// serialises each word as OUT_W-bit beats with a clk_out strobe.
// Optional feature macro: COM_DROP_COUNT_EN adds an 8-bit saturating DropCount.
module com_stream_tx
   import com_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int OUT_W       = 8,
   parameter int DEPTH       = 8,
   parameter int HALF_PERIOD = 2,
   parameter int MSB_FIRST   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemtoReg,
   input  logic              COM,
   input  logic [DATA_W-1:0] ReadData,
   input  logic              OutReady,
   output logic              clk_out,
   output logic [OUT_W-1:0]  ReadDataOut,
   output logic              Busy,
   output logic              FifoFull,
`ifdef COM_DROP_COUNT_EN
   output logic [DROP_CNT_W-1:0] DropCount,
`endif
   output logic              Overflow
);

   localparam int BEATS = beats(DATA_W, OUT_W);
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = $clog2(HALF_PERIOD + 1);
   localparam int BW    = $clog2(BEATS + 1);

   com_state_e        state_q, state_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [OUT_W-1:0]  dout_q, dout_d;
   logic              overflow_q;

   logic              push_req, pop, drop, phase_done;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full, fifo_empty;
   logic [AW:0]       fifo_count;

   // Beat presented first from a word, according to ordering
   function automatic logic [OUT_W-1:0] first_beat(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1 -: OUT_W] : w[OUT_W-1:0];
   endfunction

   // Word with the current front beat consumed
   function automatic logic [DATA_W-1:0] consume(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? (w << OUT_W) : (w >> OUT_W);
   endfunction

   assign push_req = COM && MemtoReg;
   assign drop     = push_req && fifo_full && !pop;

   com_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_req),
      .pop_i   (pop),
      .din_i   (ReadData),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign phase_done  = (phase_q == PW'(HALF_PERIOD - 1));
   assign clk_out     = (state_q == HIGH);
   assign Busy        = (state_q != IDLE);
   assign ReadDataOut = dout_q;
   assign FifoFull    = (fifo_count == (AW+1)'(DEPTH));
   assign Overflow    = overflow_q;

   // Serialiser next state: OutReady only consulted at word boundaries
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      beat_d  = beat_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && OutReady) begin
               pop     = 1'b1;
               dout_d  = first_beat(fifo_dout);
               shreg_d = consume(fifo_dout);
               beat_d  = BW'(BEATS - 1);
               phase_d = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (phase_done) begin
               phase_d = '0;
               state_d = HIGH;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         HIGH: begin
            if (phase_done) begin
               phase_d = '0;
               if (beat_q != '0) begin
                  dout_d  = first_beat(shreg_q);
                  shreg_d = consume(shreg_q);
                  beat_d  = beat_q - 1'b1;
                  state_d = LOW;
               end else if (!fifo_empty && OutReady) begin
                  pop     = 1'b1;
                  dout_d  = first_beat(fifo_dout);
                  shreg_d = consume(fifo_dout);
                  beat_d  = BW'(BEATS - 1);
                  state_d = LOW;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Serialiser and sticky overflow registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         beat_q     <= '0;
         shreg_q    <= '0;
         dout_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         beat_q  <= beat_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         if (drop) overflow_q <= 1'b1;
      end
   end

`ifdef COM_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   // Saturating count of dropped words
   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt_q <= '0;
      else if (drop && (drop_cnt_q != '1))
         drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign DropCount = drop_cnt_q;
`endif

endmodule
